// File: rtl/wchan_router.sv
// wchan_router: forward-path AXI write router for master M1.
// Latches one AW burst, decodes it to S0, S1 or the default slave (DS), then
// steers the W beats to that slave. It stays locked until the M1 B handshake.
// Slave-side IDs are widened to {MASTER_TAG, AWID} for the return-path mux.
module wchan_router #(
    parameter int              ID_W       = 4,
    parameter int              IDS_W      = 8,
    parameter int              ADDR_W     = 32,
    parameter int              DATA_W     = 32,
    parameter logic [3:0]      MASTER_TAG = 4'd1,
    parameter logic [ADDR_W-1:0] S0_BASE  = 32'h0000_0000,
    parameter logic [ADDR_W-1:0] S1_BASE  = 32'h0001_0000
) (
    input  logic                clk,
    input  logic                rst,
    // M1 write address channel
    input  logic [ID_W-1:0]     M1_AWID,
    input  logic [ADDR_W-1:0]   M1_AWADDR,
    input  logic [3:0]          M1_AWLEN,
    input  logic [2:0]          M1_AWSIZE,
    input  logic [1:0]          M1_AWBURST,
    input  logic                M1_AWVALID,
    output logic                M1_AWREADY,
    // M1 write data channel
    input  logic [DATA_W-1:0]   M1_WDATA,
    input  logic [DATA_W/8-1:0] M1_WSTRB,
    input  logic                M1_WLAST,
    input  logic                M1_WVALID,
    output logic                M1_WREADY,
    // snooped M1 write response handshake
    input  logic                M1_BVALID,
    input  logic                M1_BREADY,
    // S0
    output logic [IDS_W-1:0]    S0_AWID,
    output logic [ADDR_W-1:0]   S0_AWADDR,
    output logic [3:0]          S0_AWLEN,
    output logic [2:0]          S0_AWSIZE,
    output logic [1:0]          S0_AWBURST,
    output logic                S0_AWVALID,
    input  logic                S0_AWREADY,
    output logic [DATA_W-1:0]   S0_WDATA,
    output logic [DATA_W/8-1:0] S0_WSTRB,
    output logic                S0_WLAST,
    output logic                S0_WVALID,
    input  logic                S0_WREADY,
    // S1
    output logic [IDS_W-1:0]    S1_AWID,
    output logic [ADDR_W-1:0]   S1_AWADDR,
    output logic [3:0]          S1_AWLEN,
    output logic [2:0]          S1_AWSIZE,
    output logic [1:0]          S1_AWBURST,
    output logic                S1_AWVALID,
    input  logic                S1_AWREADY,
    output logic [DATA_W-1:0]   S1_WDATA,
    output logic [DATA_W/8-1:0] S1_WSTRB,
    output logic                S1_WLAST,
    output logic                S1_WVALID,
    input  logic                S1_WREADY,
    // default slave
    output logic [IDS_W-1:0]    DS_AWID,
    output logic [ADDR_W-1:0]   DS_AWADDR,
    output logic [3:0]          DS_AWLEN,
    output logic [2:0]          DS_AWSIZE,
    output logic [1:0]          DS_AWBURST,
    output logic                DS_AWVALID,
    input  logic                DS_AWREADY,
    output logic [DATA_W-1:0]   DS_WDATA,
    output logic [DATA_W/8-1:0] DS_WSTRB,
    output logic                DS_WLAST,
    output logic                DS_WVALID,
    input  logic                DS_WREADY,
    // M1_WLAST disagreed with the regenerated last on a W handshake
    output logic                WLAST_ERR
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_AW   = 2'd1;
    localparam logic [1:0] ST_W    = 2'd2;
    localparam logic [1:0] ST_B    = 2'd3;

    // sel bit order: [0]=S0, [1]=S1, [2]=DS
    logic [1:0]        state_q, state_d;
    logic [2:0]        sel_q, sel_d;
    logic [3:0]        beat_q, beat_d;
    logic [ID_W-1:0]   awid_q, awid_d;
    logic [ADDR_W-1:0] awaddr_q, awaddr_d;
    logic [3:0]        awlen_q, awlen_d;
    logic [2:0]        awsize_q, awsize_d;
    logic [1:0]        awburst_q, awburst_d;

    logic       run;
    logic [2:0] dec_sel;
    logic       sel_awready, sel_wready;
    logic       aw_hs, w_hs, b_hs, last_beat;
    logic [2:0] awvalid_vec, wvalid_vec;

    assign run = ~rst;

    // Address decode with S0 taking precedence over S1, everything else to DS
    always_comb begin
        dec_sel = 3'b100;
        if (M1_AWADDR[ADDR_W-1:16] == S0_BASE[ADDR_W-1:16]) begin
            dec_sel = 3'b001;
        end else if (M1_AWADDR[ADDR_W-1:16] == S1_BASE[ADDR_W-1:16]) begin
            dec_sel = 3'b010;
        end
    end

    assign sel_awready = |(sel_q & {DS_AWREADY, S1_AWREADY, S0_AWREADY});
    assign sel_wready  = |(sel_q & {DS_WREADY, S1_WREADY, S0_WREADY});
    assign aw_hs       = (state_q == ST_IDLE) && M1_AWVALID;
    assign w_hs        = (state_q == ST_W) && M1_WVALID && sel_wready;
    assign b_hs        = M1_BVALID && M1_BREADY;
    assign last_beat   = (beat_q == awlen_q);

    // Next-state logic: burst sequencing and AW field capture
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        beat_d    = beat_q;
        awid_d    = awid_q;
        awaddr_d  = awaddr_q;
        awlen_d   = awlen_q;
        awsize_d  = awsize_q;
        awburst_d = awburst_q;
        case (state_q)
            ST_IDLE: begin
                if (aw_hs) begin
                    state_d   = ST_AW;
                    sel_d     = dec_sel;
                    awid_d    = M1_AWID;
                    awaddr_d  = M1_AWADDR;
                    awlen_d   = M1_AWLEN;
                    awsize_d  = M1_AWSIZE;
                    awburst_d = M1_AWBURST;
                end
            end
            ST_AW: begin
                if (sel_awready) begin
                    state_d = ST_W;
                    beat_d  = '0;
                end
            end
            ST_W: begin
                // AWLEN alone ends the burst; M1_WLAST is only checked
                if (w_hs) begin
                    if (last_beat) begin
                        state_d = ST_B;
                    end else begin
                        beat_d = beat_q + 4'd1;
                    end
                end
            end
            default: begin
                if (b_hs) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            sel_q     <= '0;
            beat_q    <= '0;
            awid_q    <= '0;
            awaddr_q  <= '0;
            awlen_q   <= '0;
            awsize_q  <= '0;
            awburst_q <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            beat_q    <= beat_d;
            awid_q    <= awid_d;
            awaddr_q  <= awaddr_d;
            awlen_q   <= awlen_d;
            awsize_q  <= awsize_d;
            awburst_q <= awburst_d;
        end
    end

    // Every output is forced low while reset is held
    assign M1_AWREADY  = run && (state_q == ST_IDLE);
    assign M1_WREADY   = run && (state_q == ST_W) && sel_wready;
    assign WLAST_ERR   = run && w_hs && (M1_WLAST != last_beat);
    assign awvalid_vec = (run && state_q == ST_AW) ? sel_q : 3'b000;
    assign wvalid_vec  = (run && state_q == ST_W && M1_WVALID) ? sel_q : 3'b000;

    assign {DS_AWVALID, S1_AWVALID, S0_AWVALID} = awvalid_vec;
    assign {DS_WVALID,  S1_WVALID,  S0_WVALID}  = wvalid_vec;

    assign S0_AWID    = run ? {MASTER_TAG, awid_q} : '0;
    assign S1_AWID    = S0_AWID;
    assign DS_AWID    = S0_AWID;
    assign S0_AWADDR  = run ? awaddr_q : '0;
    assign S1_AWADDR  = S0_AWADDR;
    assign DS_AWADDR  = S0_AWADDR;
    assign S0_AWLEN   = run ? awlen_q : '0;
    assign S1_AWLEN   = S0_AWLEN;
    assign DS_AWLEN   = S0_AWLEN;
    assign S0_AWSIZE  = run ? awsize_q : '0;
    assign S1_AWSIZE  = S0_AWSIZE;
    assign DS_AWSIZE  = S0_AWSIZE;
    assign S0_AWBURST = run ? awburst_q : '0;
    assign S1_AWBURST = S0_AWBURST;
    assign DS_AWBURST = S0_AWBURST;

    assign S0_WDATA   = run ? M1_WDATA : '0;
    assign S1_WDATA   = S0_WDATA;
    assign DS_WDATA   = S0_WDATA;
    assign S0_WSTRB   = run ? M1_WSTRB : '0;
    assign S1_WSTRB   = S0_WSTRB;
    assign DS_WSTRB   = S0_WSTRB;
    assign S0_WLAST   = run && (state_q == ST_W) && last_beat;
    assign S1_WLAST   = S0_WLAST;
    assign DS_WLAST   = S0_WLAST;

endmodule

// File: tb/tb_wchan_router.sv
// Directed bench for wchan_router: a table of bursts driven through a common
// burst task, plus a hand-written mid-burst reset sequence.
module tb_wchan_router;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  M1_AWID;
    logic [31:0] M1_AWADDR;
    logic [3:0]  M1_AWLEN;
    logic [2:0]  M1_AWSIZE;
    logic [1:0]  M1_AWBURST;
    logic        M1_AWVALID, M1_AWREADY;
    logic [31:0] M1_WDATA;
    logic [3:0]  M1_WSTRB;
    logic        M1_WLAST, M1_WVALID, M1_WREADY;
    logic        M1_BVALID, M1_BREADY;
    logic [7:0]  S0_AWID, S1_AWID, DS_AWID;
    logic [31:0] S0_AWADDR, S1_AWADDR, DS_AWADDR;
    logic [3:0]  S0_AWLEN, S1_AWLEN, DS_AWLEN;
    logic [2:0]  S0_AWSIZE, S1_AWSIZE, DS_AWSIZE;
    logic [1:0]  S0_AWBURST, S1_AWBURST, DS_AWBURST;
    logic        S0_AWVALID, S1_AWVALID, DS_AWVALID;
    logic [31:0] S0_WDATA, S1_WDATA, DS_WDATA;
    logic [3:0]  S0_WSTRB, S1_WSTRB, DS_WSTRB;
    logic        S0_WLAST, S1_WLAST, DS_WLAST;
    logic        S0_WVALID, S1_WVALID, DS_WVALID;
    logic        WLAST_ERR;
    logic [2:0]  s_awready, s_wready;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    wchan_router #(
        .ID_W(4), .IDS_W(8), .ADDR_W(32), .DATA_W(32), .MASTER_TAG(4'd1),
        .S0_BASE(32'h0000_0000), .S1_BASE(32'h0001_0000)
    ) dut (
        .clk(clk), .rst(rst),
        .M1_AWID(M1_AWID), .M1_AWADDR(M1_AWADDR), .M1_AWLEN(M1_AWLEN),
        .M1_AWSIZE(M1_AWSIZE), .M1_AWBURST(M1_AWBURST),
        .M1_AWVALID(M1_AWVALID), .M1_AWREADY(M1_AWREADY),
        .M1_WDATA(M1_WDATA), .M1_WSTRB(M1_WSTRB), .M1_WLAST(M1_WLAST),
        .M1_WVALID(M1_WVALID), .M1_WREADY(M1_WREADY),
        .M1_BVALID(M1_BVALID), .M1_BREADY(M1_BREADY),
        .S0_AWID(S0_AWID), .S0_AWADDR(S0_AWADDR), .S0_AWLEN(S0_AWLEN),
        .S0_AWSIZE(S0_AWSIZE), .S0_AWBURST(S0_AWBURST),
        .S0_AWVALID(S0_AWVALID), .S0_AWREADY(s_awready[0]),
        .S0_WDATA(S0_WDATA), .S0_WSTRB(S0_WSTRB), .S0_WLAST(S0_WLAST),
        .S0_WVALID(S0_WVALID), .S0_WREADY(s_wready[0]),
        .S1_AWID(S1_AWID), .S1_AWADDR(S1_AWADDR), .S1_AWLEN(S1_AWLEN),
        .S1_AWSIZE(S1_AWSIZE), .S1_AWBURST(S1_AWBURST),
        .S1_AWVALID(S1_AWVALID), .S1_AWREADY(s_awready[1]),
        .S1_WDATA(S1_WDATA), .S1_WSTRB(S1_WSTRB), .S1_WLAST(S1_WLAST),
        .S1_WVALID(S1_WVALID), .S1_WREADY(s_wready[1]),
        .DS_AWID(DS_AWID), .DS_AWADDR(DS_AWADDR), .DS_AWLEN(DS_AWLEN),
        .DS_AWSIZE(DS_AWSIZE), .DS_AWBURST(DS_AWBURST),
        .DS_AWVALID(DS_AWVALID), .DS_AWREADY(s_awready[2]),
        .DS_WDATA(DS_WDATA), .DS_WSTRB(DS_WSTRB), .DS_WLAST(DS_WLAST),
        .DS_WVALID(DS_WVALID), .DS_WREADY(s_wready[2]),
        .WLAST_ERR(WLAST_ERR)
    );

    // Per-slave views indexed 0=S0, 1=S1, 2=DS
    logic [2:0]  awvalid_v, wvalid_v, wlast_v;
    logic [7:0]  awid_a [3];
    logic [31:0] awaddr_a [3];
    logic [31:0] wdata_a [3];
    logic [3:0]  awlen_a [3];
    logic [4:0]  szbu_a [3];
    logic        any_out;

    assign awvalid_v = {DS_AWVALID, S1_AWVALID, S0_AWVALID};
    assign wvalid_v  = {DS_WVALID, S1_WVALID, S0_WVALID};
    assign wlast_v   = {DS_WLAST, S1_WLAST, S0_WLAST};
    assign awid_a[0] = S0_AWID;   assign awid_a[1] = S1_AWID;   assign awid_a[2] = DS_AWID;
    assign awaddr_a[0] = S0_AWADDR; assign awaddr_a[1] = S1_AWADDR; assign awaddr_a[2] = DS_AWADDR;
    assign wdata_a[0] = S0_WDATA; assign wdata_a[1] = S1_WDATA; assign wdata_a[2] = DS_WDATA;
    assign awlen_a[0] = S0_AWLEN; assign awlen_a[1] = S1_AWLEN; assign awlen_a[2] = DS_AWLEN;
    assign szbu_a[0] = {S0_AWSIZE, S0_AWBURST};
    assign szbu_a[1] = {S1_AWSIZE, S1_AWBURST};
    assign szbu_a[2] = {DS_AWSIZE, DS_AWBURST};
    assign any_out = |{M1_AWREADY, M1_WREADY, WLAST_ERR,
                       S0_AWID, S0_AWADDR, S0_AWLEN, S0_AWSIZE, S0_AWBURST, S0_AWVALID,
                       S0_WDATA, S0_WSTRB, S0_WLAST, S0_WVALID,
                       S1_AWID, S1_AWADDR, S1_AWLEN, S1_AWSIZE, S1_AWBURST, S1_AWVALID,
                       S1_WDATA, S1_WSTRB, S1_WLAST, S1_WVALID,
                       DS_AWID, DS_AWADDR, DS_AWLEN, DS_AWSIZE, DS_AWBURST, DS_AWVALID,
                       DS_WDATA, DS_WSTRB, DS_WLAST, DS_WVALID};

    typedef struct {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [3:0]  len;
        int          idx;    // expected slave
        int          awdly;  // cycles with slave AWREADY low
        bit          wtog;   // insert a WREADY-low cycle before each beat
        int          bad;    // beat index with a spurious M1_WLAST, -1 for none
        int          bdly;   // idle cycles in B before the handshake
    } vec_t;

    vec_t vt [7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_burst(input vec_t v);
        logic [2:0]  es;
        logic [31:0] data;
        es = 3'b001 << v.idx;
        M1_AWID = v.id; M1_AWADDR = v.addr; M1_AWLEN = v.len;
        M1_AWSIZE = 3'd2; M1_AWBURST = 2'b01; M1_AWVALID = 1'b1;
        #1;
        chk("awready_idle", M1_AWREADY, 1);
        chk("awvalid_idle", awvalid_v, 0);
        tick();
        // Perturb the master bus to prove the slave sees latched fields,
        // and offer a W beat early to prove it is not accepted yet.
        M1_AWVALID = 1'b0; M1_AWADDR = 32'hFFFF_FFFF; M1_AWID = ~v.id; M1_AWLEN = ~v.len;
        M1_WVALID = 1'b1; M1_WDATA = 32'h1234_5678; M1_WSTRB = 4'hF; M1_WLAST = 1'b0;
        #1;
        for (int c = 0; c <= v.awdly; c++) begin
            chk("aw_sel_valid", awvalid_v, es);
            chk("aw_id", awid_a[v.idx], {4'h1, v.id});
            chk("aw_addr", awaddr_a[v.idx], v.addr);
            chk("aw_len", awlen_a[v.idx], v.len);
            chk("aw_size_burst", szbu_a[v.idx], 5'b010_01);
            chk("aw_awready_low", M1_AWREADY, 0);
            chk("aw_no_wready", M1_WREADY, 0);
            chk("aw_no_wvalid", wvalid_v, 0);
            if (c == v.awdly) s_awready = 3'b111;
            tick();
        end
        s_awready = 3'b000;
        for (int b = 0; b <= int'(v.len); b++) begin
            data = 32'hDEAD_BEEF + b;
            M1_WDATA = data; M1_WSTRB = 4'hF;
            M1_WLAST = (b == int'(v.len)) || (b == v.bad);
            M1_WVALID = 1'b1;
            if (v.wtog) begin
                s_wready = 3'b000;
                #1;
                chk("w_stall_valid", wvalid_v, es);
                chk("w_stall_ready", M1_WREADY, 0);
                chk("w_stall_err", WLAST_ERR, 0);
                chk("w_stall_last", wlast_v[v.idx], b == int'(v.len));
                tick();
            end
            s_wready = 3'b111;
            #1;
            chk("w_valid", wvalid_v, es);
            chk("w_ready", M1_WREADY, 1);
            chk("w_data", wdata_a[v.idx], data);
            chk("w_last", wlast_v[v.idx], b == int'(v.len));
            chk("wlast_err", WLAST_ERR, (b == v.bad) && (b != int'(v.len)));
            tick();
        end
        M1_WVALID = 1'b0; M1_WLAST = 1'b0; s_wready = 3'b000;
        #1;
        chk("b_awready", M1_AWREADY, 0);
        chk("b_wvalid", wvalid_v, 0);
        chk("b_awvalid", awvalid_v, 0);
        for (int d = 0; d < v.bdly; d++) begin
            tick();
            chk("b_wait_awready", M1_AWREADY, 0);
        end
        M1_BVALID = 1'b1; M1_BREADY = 1'b1;
        #1;
        chk("b_hs_awready", M1_AWREADY, 0);
        tick();
        M1_BVALID = 1'b0; M1_BREADY = 1'b0;
        #1;
        chk("post_b_awready", M1_AWREADY, 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{4'h3, 32'h0000_0010, 4'd0,  0, 0, 1'b0, -1, 0};
        vt[1] = '{4'h5, 32'h0001_0004, 4'd3,  1, 0, 1'b0, -1, 2};
        vt[2] = '{4'h9, 32'h8000_0000, 4'd1,  2, 0, 1'b0, -1, 1};
        vt[3] = '{4'hA, 32'h0001_FFF0, 4'd2,  1, 5, 1'b1, -1, 0};
        vt[4] = '{4'h7, 32'h0001_0100, 4'd3,  1, 0, 1'b0,  1, 0};
        vt[5] = '{4'hF, 32'h0000_FFFC, 4'd15, 0, 1, 1'b0, -1, 0};
        vt[6] = '{4'h0, 32'h0002_0000, 4'd0,  2, 0, 1'b1, -1, 3};

        rst = 1'b1;
        M1_AWID = '0; M1_AWADDR = '0; M1_AWLEN = '0; M1_AWSIZE = '0; M1_AWBURST = '0;
        M1_AWVALID = 1'b1; M1_WDATA = 32'hFFFF_FFFF; M1_WSTRB = 4'hF; M1_WLAST = 1'b1;
        M1_WVALID = 1'b1; M1_BVALID = 1'b0; M1_BREADY = 1'b0;
        s_awready = 3'b111; s_wready = 3'b111;
        tick();
        tick();
        chk("reset_outputs_zero", any_out, 0);
        rst = 1'b0;
        M1_AWVALID = 1'b0; M1_WVALID = 1'b0; M1_WLAST = 1'b0;
        s_awready = 3'b000; s_wready = 3'b000;
        #1;
        chk("reset_awready", M1_AWREADY, 1);
        chk("reset_awvalid", awvalid_v, 0);
        chk("reset_wvalid", wvalid_v, 0);
        tick();

        for (int i = 0; i < 7; i++) begin
            do_burst(vt[i]);
        end

        // Reset during beat 2 of a LEN=3 burst to S1
        M1_AWID = 4'h2; M1_AWADDR = 32'h0001_0000; M1_AWLEN = 4'd3;
        M1_AWSIZE = 3'd2; M1_AWBURST = 2'b01; M1_AWVALID = 1'b1;
        tick();
        M1_AWVALID = 1'b0; s_awready = 3'b111;
        tick();
        s_awready = 3'b000;
        M1_WVALID = 1'b1; M1_WDATA = 32'hA5A5_0000; s_wready = 3'b111;
        #1;
        chk("rst_seq_beat1", S1_WVALID, 1);
        tick();
        M1_WDATA = 32'hA5A5_0001;
        rst = 1'b1;
        #1;
        chk("rst_mid_zero", any_out, 0);
        tick();
        chk("rst_held_zero", any_out, 0);
        rst = 1'b0; M1_WVALID = 1'b0; s_wready = 3'b000;
        #1;
        chk("rst_rel_awready", M1_AWREADY, 1);
        chk("rst_rel_awvalid", awvalid_v, 0);
        chk("rst_rel_wvalid", wvalid_v, 0);
        tick();
        do_burst('{4'h6, 32'h0000_0200, 4'd1, 0, 0, 1'b0, -1, 0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
